// File: rtl/riscv_pkg.sv
// ------------------------------------------------------------------
// riscv_pkg: shared fetch-side types and constants
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

package riscv_pkg;

  localparam int          INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h00000013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    KILL  = 2'd2,
    VALID = 2'd3
  } fetch_state_e;

endpackage : riscv_pkg

`default_nettype wire

// File: rtl/fetch_pc_reg.sv
// ------------------------------------------------------------------
// fetch_pc_reg: program counter with +4 step, target alignment, misalign flag
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module fetch_pc_reg
  import riscv_pkg::*;
#(
  parameter int                    WORDSIZE = 64,
  parameter logic [WORDSIZE-1:0]   RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                redirect,
  input  logic [WORDSIZE-1:0] redirect_pc,
  input  logic                load_target,
  input  logic                load_alt,
  input  logic [WORDSIZE-1:0] alt_pc,
  input  logic                inc,
  output logic [WORDSIZE-1:0] pc,
  output logic [WORDSIZE-1:0] target,
  output logic                misaligned_err
);

  localparam logic [WORDSIZE-1:0] PC_STEP = WORDSIZE'(INSTR_BYTES);

  logic [WORDSIZE-1:0] pc_d, pc_q;
  logic                err_d, err_q;

  assign target = {redirect_pc[WORDSIZE-1:2], 2'b00};

  always_comb begin
    pc_d  = pc_q;
    err_d = err_q | (redirect & (|redirect_pc[1:0]));
    if (load_target) begin
      pc_d = target;
    end else if (load_alt) begin
      pc_d = alt_pc;
    end else if (inc) begin
      pc_d = pc_q + PC_STEP;  // wraps modulo 2^WORDSIZE
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

  assign pc             = pc_q;
  assign misaligned_err = err_q;

endmodule : fetch_pc_reg

`default_nettype wire

// File: rtl/instruction_fetch.sv
// ------------------------------------------------------------------
// instruction_fetch: PC-owning fetch FSM, req/ack memory side, valid/ready output
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module instruction_fetch
  import riscv_pkg::*;
#(
  parameter int                  WORDSIZE         = 64,
  parameter int                  INSTRUCTION_SIZE = 32,
  parameter logic [WORDSIZE-1:0] RESET_PC         = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic                        imem_req,
  output logic [WORDSIZE-1:0]         imem_addr,
  input  logic                        imem_ack,
  input  logic [INSTRUCTION_SIZE-1:0] imem_rdata,
  input  logic                        redirect,
  input  logic [WORDSIZE-1:0]         redirect_pc,
  output logic [INSTRUCTION_SIZE-1:0] instruction,
  output logic [WORDSIZE-1:0]         instr_pc,
  output logic                        instr_valid,
  input  logic                        instr_ready,
  output logic                        misaligned_err
);

  localparam logic [INSTRUCTION_SIZE-1:0] NOP = INSTRUCTION_SIZE'(NOP_INSTR);

  fetch_state_e                state_d, state_q;
  logic [WORDSIZE-1:0]         kill_pc_d, kill_pc_q;
  logic [INSTRUCTION_SIZE-1:0] instr_d, instr_q;
  logic [WORDSIZE-1:0]         instr_pc_d, instr_pc_q;
  logic                        valid_d, valid_q;

  logic                        load_target;
  logic                        load_alt;
  logic                        inc;
  logic [WORDSIZE-1:0]         pc;
  logic [WORDSIZE-1:0]         target;

  fetch_pc_reg #(
    .WORDSIZE (WORDSIZE),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .load_target    (load_target),
    .load_alt       (load_alt),
    .alt_pc         (kill_pc_q),
    .inc            (inc),
    .pc             (pc),
    .target         (target),
    .misaligned_err (misaligned_err)
  );

  always_comb begin
    state_d     = state_q;
    kill_pc_d   = kill_pc_q;
    instr_d     = instr_q;
    instr_pc_d  = instr_pc_q;
    valid_d     = valid_q;
    load_target = 1'b0;
    load_alt    = 1'b0;
    inc         = 1'b0;
    case (state_q)
      IDLE: begin
        state_d     = FETCH;
        load_target = redirect;
      end
      FETCH: begin
        if (imem_ack) begin
          if (redirect) begin
            load_target = 1'b1;
          end else begin
            instr_d    = imem_rdata;
            instr_pc_d = pc;
            valid_d    = 1'b1;
            state_d    = VALID;
          end
        end else if (redirect) begin
          kill_pc_d = target;
          state_d   = KILL;
        end
      end
      // The old request must complete before the new pc can be issued.
      KILL: begin
        if (imem_ack) begin
          load_target = redirect;
          load_alt    = ~redirect;
          state_d     = FETCH;
        end else if (redirect) begin
          kill_pc_d = target;
        end
      end
      VALID: begin
        if (redirect) begin
          valid_d     = 1'b0;
          load_target = 1'b1;
          state_d     = FETCH;
        end else if (instr_ready) begin
          valid_d = 1'b0;
          inc     = 1'b1;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      kill_pc_q  <= '0;
      instr_q    <= NOP;
      instr_pc_q <= RESET_PC;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      kill_pc_q  <= kill_pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
    end
  end

  assign imem_req    = (state_q == FETCH) || (state_q == KILL);
  assign imem_addr   = pc;
  assign instruction = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;

endmodule : instruction_fetch

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// ------------------------------------------------------------------
// tb_instruction_fetch: table-driven and directed checks for instruction_fetch
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic [31:0] instruction;
  logic [63:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        misaligned_err;

  int n_cmp = 0;
  int n_err = 0;

  // memory model controls
  int   latency;
  int   wait_cnt;
  logic force_ack;
  logic beef;

  always #5 clk = ~clk;

  instruction_fetch #(
    .WORDSIZE         (64),
    .INSTRUCTION_SIZE (32),
    .RESET_PC         (64'h0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .instruction    (instruction),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .misaligned_err (misaligned_err)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    wait_cnt <= 0;
    else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
    else                           wait_cnt <= 0;
  end

  always_comb begin
    imem_ack = force_ack | (imem_req && (wait_cnt >= latency));
    if (imem_addr == 64'h0)               imem_rdata = 32'h00A00093;
    else if (beef && imem_addr == 64'h8)  imem_rdata = 32'hDEADBEEF;
    else                                  imem_rdata = {imem_addr[29:0], 2'b11} ^ 32'hA5000000;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 64'h0;
    instr_ready = 1'b0;
    force_ack   = 1'b0;
    beef        = 1'b0;
    @(posedge clk);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  typedef struct {
    logic        ready;
    logic        redir;
    logic [63:0] rpc;
    logic        e_req;
    logic [63:0] e_addr;
    logic        e_valid;
    logic [63:0] e_ipc;
    logic [31:0] e_instr;
  } vec_t;

  localparam int NV = 12;
  vec_t vec [NV];

  initial begin
    int   n;
    int   guard;
    logic found;
    logic seen_bad;

    //            rdy   rdr   rpc     req   addr    vld   ipc     instr
    vec[0]  = '{1'b1, 1'b0, 64'h0,  1'b0, 64'h0,  1'b0, 64'h0,  32'h0};
    vec[1]  = '{1'b1, 1'b0, 64'h0,  1'b1, 64'h0,  1'b0, 64'h0,  32'h0};
    vec[2]  = '{1'b1, 1'b0, 64'h0,  1'b0, 64'h0,  1'b1, 64'h0,  32'h00A00093};
    vec[3]  = '{1'b1, 1'b0, 64'h0,  1'b1, 64'h4,  1'b0, 64'h0,  32'h0};
    vec[4]  = '{1'b1, 1'b0, 64'h0,  1'b0, 64'h4,  1'b1, 64'h4,  32'hA5000013};
    vec[5]  = '{1'b1, 1'b0, 64'h0,  1'b1, 64'h8,  1'b0, 64'h0,  32'h0};
    vec[6]  = '{1'b1, 1'b1, 64'h40, 1'b0, 64'h8,  1'b1, 64'h8,  32'hA5000023};
    vec[7]  = '{1'b0, 1'b0, 64'h0,  1'b1, 64'h40, 1'b0, 64'h0,  32'h0};
    vec[8]  = '{1'b0, 1'b0, 64'h0,  1'b0, 64'h40, 1'b1, 64'h40, 32'hA5000103};
    vec[9]  = '{1'b0, 1'b0, 64'h0,  1'b0, 64'h40, 1'b1, 64'h40, 32'hA5000103};
    vec[10] = '{1'b1, 1'b0, 64'h0,  1'b0, 64'h40, 1'b1, 64'h40, 32'hA5000103};
    vec[11] = '{1'b1, 1'b0, 64'h0,  1'b1, 64'h44, 1'b0, 64'h0,  32'h0};

    latency = 0;
    apply_reset();
    @(posedge clk);
    @(negedge clk);
    check("rst_req",   imem_req,       0);
    check("rst_valid", instr_valid,    0);
    check("rst_instr", instruction,    32'h00000013);
    check("rst_ipc",   instr_pc,       0);
    check("rst_err",   misaligned_err, 0);

    // zero-wait stream plus redirect-vs-ready priority in VALID
    instr_ready = 1'b1;
    release_reset();
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      check($sformatf("v%0d_req", i),   imem_req,    vec[i].e_req);
      check($sformatf("v%0d_addr", i),  imem_addr,   vec[i].e_addr);
      check($sformatf("v%0d_valid", i), instr_valid, vec[i].e_valid);
      if (vec[i].e_valid) begin
        check($sformatf("v%0d_ipc", i),   instr_pc,    vec[i].e_ipc);
        check($sformatf("v%0d_instr", i), instruction, vec[i].e_instr);
      end
      instr_ready = vec[i].ready;
      redirect    = vec[i].redir;
      redirect_pc = vec[i].rpc;
    end
    redirect = 1'b0;

    // A: 3-cycle ack delay, consumer stalls
    apply_reset();
    latency = 3;
    release_reset();
    @(negedge clk);
    check("A_idle_req", imem_req, 0);
    n = 0;
    guard = 0;
    @(negedge clk);
    while (imem_req && guard < 20) begin
      check("A_addr", imem_addr, 0);
      n++;
      guard++;
      @(negedge clk);
    end
    check("A_req_cycles", n, 4);
    for (int k = 0; k < 5; k++) begin
      check("A_valid", instr_valid, 1);
      check("A_instr", instruction, 32'h00A00093);
      check("A_ipc",   instr_pc,    0);
      check("A_noreq", imem_req,    0);
      @(negedge clk);
    end
    instr_ready = 1'b1;
    @(negedge clk);
    check("A_next_req",  imem_req,  1);
    check("A_next_addr", imem_addr, 64'h4);

    // B: redirect while the fetch at 0x8 is outstanding
    apply_reset();
    latency = 2;
    beef = 1'b1;
    instr_ready = 1'b1;
    release_reset();
    found = 1'b0;
    for (int g = 0; g < 60; g++) begin
      @(negedge clk);
      if (imem_req && imem_addr == 64'h8) begin
        found = 1'b1;
        break;
      end
    end
    check("B_reach8", found, 1);
    redirect    = 1'b1;
    redirect_pc = 64'h100;
    instr_ready = 1'b0;
    @(negedge clk);
    redirect = 1'b0;
    check("B_kill_req",  imem_req,  1);
    check("B_kill_addr", imem_addr, 64'h8);
    seen_bad = 1'b0;
    for (int g = 0; g < 20; g++) begin
      if (imem_addr != 64'h8) break;
      if (instr_valid) seen_bad = 1'b1;
      @(negedge clk);
    end
    check("B_next_addr", imem_addr, 64'h100);
    check("B_next_req",  imem_req,  1);
    for (int g = 0; g < 20; g++) begin
      if (instr_valid) break;
      @(negedge clk);
    end
    check("B_valid",    instr_valid, 1);
    check("B_ipc",      instr_pc,    64'h100);
    check("B_instr",    instruction, 32'hA5000403);
    check("B_no_stale", seen_bad,    0);

    // C: misaligned redirect target
    check("C_err_before", misaligned_err, 0);
    redirect    = 1'b1;
    redirect_pc = 64'h102;
    @(negedge clk);
    redirect = 1'b0;
    check("C_req",  imem_req,       1);
    check("C_addr", imem_addr,      64'h100);
    check("C_err",  misaligned_err, 1);
    repeat (6) @(negedge clk);
    check("C_err_sticky", misaligned_err, 1);

    // D: pc wrap, then reset mid-fetch and a stray ack in IDLE
    for (int g = 0; g < 20; g++) begin
      if (instr_valid) break;
      @(negedge clk);
    end
    check("D_pre_valid", instr_valid, 1);
    redirect    = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    latency     = 0;
    @(negedge clk);
    redirect = 1'b0;
    check("D_top_req",  imem_req,  1);
    check("D_top_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    @(negedge clk);
    check("D_top_valid", instr_valid, 1);
    check("D_top_ipc",   instr_pc,    64'hFFFF_FFFF_FFFF_FFFC);
    instr_ready = 1'b1;
    latency     = 5;
    @(negedge clk);
    check("D_wrap_req",   imem_req,    1);
    check("D_wrap_addr",  imem_addr,   64'h0);
    check("D_wrap_valid", instr_valid, 0);
    #2 rst_n = 1'b0;
    #1;
    check("D_rst_req",   imem_req,       0);
    check("D_rst_valid", instr_valid,    0);
    check("D_rst_instr", instruction,    32'h00000013);
    check("D_rst_ipc",   instr_pc,       0);
    check("D_rst_err",   misaligned_err, 0);
    @(negedge clk);
    rst_n       = 1'b1;
    instr_ready = 1'b0;
    force_ack   = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    check("D_stray_req",   imem_req,    1);
    check("D_stray_addr",  imem_addr,   64'h0);
    check("D_stray_valid", instr_valid, 0);
    @(negedge clk);
    check("D_stray_valid2", instr_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_instruction_fetch

`default_nettype wire

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch-side initiator that produces the 32-bit instruction word consumed by the processor's decode/control logic.
- Owns the program counter and issues word reads to instruction memory over a req/ack handshake.
- Presents each fetched instruction with a valid/ready handshake and accepts PC redirects from branch/jump resolution.

Parameters:
- WORDSIZE, 64, width of PC and memory address
- INSTRUCTION_SIZE, 32, instruction word width
- RESET_PC, 0, PC value loaded at reset

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- imem_req  output  1  read request to instruction memory
- imem_addr  output  WORDSIZE  byte address of requested word
- imem_ack  input  1  memory completes the request this cycle
- imem_rdata  input  INSTRUCTION_SIZE  read data, valid when imem_ack=1
- redirect  input  1  load a new PC (taken branch/jump)
- redirect_pc  input  WORDSIZE  redirect target byte address
- instruction  output  INSTRUCTION_SIZE  fetched instruction to decode
- instr_pc  output  WORDSIZE  PC of the presented instruction
- instr_valid  output  1  instruction/instr_pc are valid
- instr_ready  input  1  consumer accepts the instruction this cycle
- misaligned_err  output  1  sticky: a redirect target had bits [1:0] != 0

Behaviour:
- Reset, asynchronous while rst_n=0:
  - state=IDLE, pc=RESET_PC, imem_req=0, instr_valid=0.
  - instruction=32'h00000013 (NOP), instr_pc=RESET_PC, misaligned_err=0, kill_pc=0.
- imem_req=1 exactly in FETCH and KILL. imem_addr=pc in both states; it stays stable until ack.
- Memory protocol:
  - req stays high until an ack is received. imem_ack may arrive in the same cycle req rises.
  - Zero-wait memory gives a 1-cycle request.
  - imem_ack while req=0 is ignored.
- State IDLE: next cycle goes to FETCH. A redirect in IDLE sets pc=target first.
- State FETCH:
  - imem_ack=1, redirect=0: instruction<=imem_rdata, instr_pc<=pc, instr_valid<=1, go VALID.
  - imem_ack=1, redirect=1: drop the data, pc<=target, stay in FETCH.
  - imem_ack=0, redirect=1: kill_pc<=target, go KILL.
- State KILL:
  - The request is still outstanding at the old pc.
  - A further redirect overwrites kill_pc.
  - On imem_ack: drop the data, pc<=kill_pc (or the redirect target if redirect is also high that cycle), go FETCH.
- State VALID:
  - instr_valid=1; instruction and instr_pc are held stable.
  - redirect=1: drop the held instruction, instr_valid<=0, pc<=target, go FETCH. Redirect has priority over instr_ready.
  - instr_ready=1, redirect=0: instr_valid<=0, pc<=pc+4, go FETCH.
  - Otherwise hold.
- Latency and throughput:
  - With a zero-wait memory, the ack cycle is followed by VALID on the next edge.
  - Sustained rate is one instruction per 2 cycles.
- Arithmetic: pc+4 is modulo 2^WORDSIZE; pc at 2^WORDSIZE-4 wraps to 0.
- Redirect target: bits [1:0] are forced to 0 before use. misaligned_err is set if they were nonzero and clears only on reset.
- Reset mid-request: everything returns to reset values immediately. A later stray imem_ack in IDLE is ignored.
- No combinational path from inputs to instr_valid or instruction; both are registered.

Decomposition:
- Shared package riscv_pkg holds:
  - fetch state enum (IDLE, FETCH, KILL, VALID; 2-bit encoding);
  - INSTR_BYTES=4;
  - NOP_INSTR=32'h00000013 (addi x0,x0,0).
- One natural sub-module: fetch_pc_reg. It holds the pc register, +4 increment, target alignment masking, and the misaligned_err flag.

Test Plan:
- Reset release with zero-wait memory returning 32'h00A00093 at 0 and instr_ready=1 -> imem_addr sequence 0,4,8; instr_valid pulses with instr_pc 0,4,8; first instruction is 32'h00A00093.
- Memory ack delayed 3 cycles with instr_ready=0 for 5 cycles -> imem_req held 4 cycles at a constant address; instruction and instr_pc stable throughout VALID; no new request until ready.
- Redirect to 0x100 while FETCH is waiting at 0x8, ack 2 cycles later carrying 32'hDEADBEEF -> data never presented; next request at 0x100; instr_pc=0x100.
- Redirect to 0x40 and instr_ready both high in VALID -> instruction dropped, next imem_addr=0x40, pc not incremented.
- Redirect to 0x102 -> fetch from 0x100; misaligned_err=1 and stays high until rst_n=0.
- pc=0xFFFF_FFFF_FFFF_FFFC accepted with instr_ready -> next imem_addr=0. Assert rst_n=0 mid-FETCH -> imem_req=0 and instruction=NOP in the same cycle.
